// File: rtl/mult_control_pkg.sv
// Shared definitions for the shift-add multiplier controller: operand width,
// counter width, FSM state encodings and the bundled select/handshake outputs.
package mult_control_pkg;

  localparam int SIZE_DATA = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Everything the controller drives towards the datapath and the system.
  typedef struct packed {
    logic aSel;
    logic bSel;
    logic prodSel;
    logic addSel;
    logic busy;
    logic done;
  } ctrlOut_t;

endpackage

// File: rtl/mult_control_if.sv
// Handshake and datapath-select bundle between the multiplier controller
// (slave side) and the surrounding datapath/system (master side).
interface mult_control_if;
  logic start;
  logic b_lsb;
  logic a_sel;
  logic b_sel;
  logic prod_sel;
  logic add_sel;
  logic busy;
  logic done;

  modport slave (
    input  start, b_lsb,
    output a_sel, b_sel, prod_sel, add_sel, busy, done
  );

  modport master (
    output start, b_lsb,
    input  a_sel, b_sel, prod_sel, add_sel, busy, done
  );
endinterface

// File: rtl/mult_control_counter.sv
// Generic up-counter: async active-low clear, synchronous clear, count enable.
// Synchronous clear wins over enable.
module counterN #(
  parameter int size = 6
) (
  input  logic            clk,
  input  logic            clrN,
  input  logic            syncClr,
  input  logic            en,
  output logic [size-1:0] count
);

  // Count register with async clear and sync clear priority.
  always_ff @(posedge clk or negedge clrN) begin
    if (!clrN)        count <= '0;
    else if (syncClr) count <= '0;
    else if (en)      count <= count + size'(1);
  end

endmodule

// File: rtl/mult_control.sv
// Control FSM for the 32x32 shift-add multiplier datapath. Sequences operand
// load (INIT), SIZE add/shift iterations (CALC) and a one-cycle DONE pulse.
// All outputs decode from registered state/cnt/lsbQ; the only combinational
// input term is reset, which forces prod_sel low while asserted.
module mult_control
  import mult_control_pkg::*;
#(
  parameter int SIZE  = SIZE_DATA,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mult_control_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt;
  logic             lsbQ;
  logic             cntClr, cntEn, lsbLoad;
  ctrlOut_t         out;

  // Iteration counter: cleared in INIT, advances once per CALC cycle, so it
  // tops out at SIZE and never wraps.
  counterN #(.size(CNT_W)) uCnt (
    .clk     (clk),
    .clrN    (reset),
    .syncClr (cntClr),
    .en      (cntEn),
    .count   (cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nextState;
  end

  // Registered copy of the next multiplier bit; b_lsb already reflects the
  // B-mux output, so this is the bit PROD must act on in the coming cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       lsbQ <= 1'b0;
    else if (lsbLoad) lsbQ <= bus.b_lsb;
  end

  // Next-state and output decode.
  always_comb begin
    nextState   = state;
    cntClr      = 1'b0;
    cntEn       = 1'b0;
    lsbLoad     = 1'b0;
    out         = '0;
    out.prodSel = 1'b1;
    case (state)
      ST_IDLE: begin
        if (bus.start) nextState = ST_INIT;
      end
      ST_INIT: begin
        out.prodSel = 1'b0;
        out.busy    = 1'b1;
        cntClr      = 1'b1;
        lsbLoad     = 1'b1;
        nextState   = ST_CALC;
      end
      ST_CALC: begin
        out.aSel   = 1'b1;
        out.bSel   = 1'b1;
        out.addSel = lsbQ;
        out.busy   = 1'b1;
        cntEn      = 1'b1;
        lsbLoad    = 1'b1;
        // Fixed iteration count; no early exit when B runs out of ones.
        if (cnt == LAST) nextState = ST_DONE;
      end
      ST_DONE: begin
        out.done  = 1'b1;
        nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
    // PROD is only cleared by the load path while reset holds; IDLE otherwise
    // keeps the previous result.
    if (!reset) out.prodSel = 1'b0;
  end

  assign bus.a_sel    = out.aSel;
  assign bus.b_sel    = out.bSel;
  assign bus.prod_sel = out.prodSel;
  assign bus.add_sel  = out.addSel;
  assign bus.busy     = out.busy;
  assign bus.done     = out.done;

endmodule
